// File: rtl/alu_bist_if.sv
// BIST-to-ALU operand/response bus. Master drives operands, slave (the ALU) returns results.
// Combinational bus, no flow control: the master holds operands until it samples the response.
interface alu_bist_if;
  logic [15:0] alu_A;
  logic [15:0] alu_B;
  logic        alu_Cin;
  logic [3:0]  alu_Mode;
  logic [15:0] alu_Y;
  logic        alu_Cout;
  logic        alu_Overflow;

  modport master (
    output alu_A, alu_B, alu_Cin, alu_Mode,
    input  alu_Y, alu_Cout, alu_Overflow
  );

  modport slave (
    input  alu_A, alu_B, alu_Cin, alu_Mode,
    output alu_Y, alu_Cout, alu_Overflow
  );
endinterface

// File: rtl/alu_bist.sv
// LFSR-driven ALU self-test with a 16-bit MISR; each vector takes SETTLE+1 cycles.
// No backpressure: start is ignored while busy, and the ALU response is sampled unconditionally.
module alu_bist #(
  parameter int          NUM_VECTORS = 64,
  parameter logic [31:0] SEED        = 32'hACE11D2B,
  parameter int          SETTLE      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  alu_bist_if.master   alu,
  output logic         busy,
  output logic         done,
  output logic [15:0]  vec_count,
  output logic [15:0]  signature
);

  // An all-zero LFSR would lock up, so a zero seed is substituted.
  localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] NUM_LAST    = 16'(NUM_VECTORS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] lfsr_step;
  logic [3:0]  mode_cnt;
  logic [3:0]  mode_next;
  logic [15:0] settle_cnt;
  logic [15:0] count_next;
  logic        last_vec;
  logic        flag_en;
  logic        cout_m;
  logic        ovf_m;
  logic [15:0] misr_shift;
  logic [15:0] misr_next;

  assign lfsr_step  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign mode_next  = mode_cnt + 4'd1;
  assign count_next = vec_count + 16'd1;
  assign last_vec   = (count_next == NUM_LAST);

  // Carry and overflow are only meaningful for the add/subtract modes.
  assign flag_en    = (alu.alu_Mode == 4'b0100) || (alu.alu_Mode == 4'b0101);
  assign cout_m     = flag_en & alu.alu_Cout;
  assign ovf_m      = flag_en & alu.alu_Overflow;
  assign misr_shift = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h8005 : 16'h0000);
  assign misr_next  = misr_shift ^ alu.alu_Y ^ {14'b0, cout_m, ovf_m};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      alu.alu_A    <= 16'h0;
      alu.alu_B    <= 16'h0;
      alu.alu_Cin  <= 1'b0;
      alu.alu_Mode <= 4'h0;
      vec_count    <= 16'h0;
      signature    <= 16'h0;
      busy         <= 1'b0;
      done         <= 1'b0;
      lfsr         <= SEED_EFF;
      mode_cnt     <= 4'h0;
      settle_cnt   <= 16'h0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            lfsr         <= SEED_EFF;
            signature    <= 16'h0;
            vec_count    <= 16'h0;
            mode_cnt     <= 4'h0;
            settle_cnt   <= 16'h0;
            alu.alu_A    <= SEED_EFF[31:16];
            alu.alu_B    <= SEED_EFF[15:0];
            alu.alu_Cin  <= SEED_EFF[31] ^ SEED_EFF[0];
            alu.alu_Mode <= 4'h0;
            busy         <= 1'b1;
            done         <= 1'b0;
            state        <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end

        ST_SAMPLE: begin
          signature  <= misr_next;
          vec_count  <= count_next;
          lfsr       <= lfsr_step;
          mode_cnt   <= mode_next;
          settle_cnt <= 16'h0;
          if (last_vec) begin
            alu.alu_A    <= 16'h0;
            alu.alu_B    <= 16'h0;
            alu.alu_Cin  <= 1'b0;
            alu.alu_Mode <= 4'h0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= ST_DONE;
          end else begin
            alu.alu_A    <= lfsr_step[31:16];
            alu.alu_B    <= lfsr_step[15:0];
            alu.alu_Cin  <= lfsr_step[31] ^ lfsr_step[0];
            alu.alu_Mode <= mode_next;
            state        <= ST_DRIVE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU on the bus, software LFSR/MISR model for expected values.
module tb_alu_bist;
  localparam int          NV     = 64;
  localparam logic [31:0] SEED   = 32'hACE11D2B;
  localparam int          PERIOD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] vec_count;
  logic [15:0] signature;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_vec  = -1;
  int inv_vec  = -1;
  int force_vec = -1;

  logic [36:0] exp_vec  [NV];
  logic        exp_cout [NV];

  alu_bist_if bus ();

  alu_bist #(.NUM_VECTORS(NV), .SEED(SEED), .SETTLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu       (bus),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count),
    .signature (signature)
  );

  always #5 clk = ~clk;

  // Reference ALU: {overflow, carry, result}; non-arithmetic modes emit junk flags on purpose.
  function automatic logic [17:0] alu_ref(input logic [3:0] m, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
    logic [16:0] t;
    logic [15:0] y;
    logic        co, ov;
    t  = 17'h0;
    y  = 16'h0;
    co = a[15] ^ b[0];
    ov = b[15];
    case (m)
      4'd0:  y = a & b;
      4'd1:  y = a | b;
      4'd2:  y = a ^ b;
      4'd3:  y = ~a;
      4'd4: begin
        t  = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        y  = t[15:0];
        co = t[16];
        ov = (a[15] == b[15]) && (y[15] != a[15]);
      end
      4'd5: begin
        t  = {1'b0, a} + {1'b0, ~b} + {16'b0, cin};
        y  = t[15:0];
        co = t[16];
        ov = (a[15] != b[15]) && (y[15] != a[15]);
      end
      4'd6:  y = a << 1;
      4'd7:  y = a >> 1;
      4'd8:  y = a + 16'd1;
      4'd9:  y = a - 16'd1;
      4'd10: y = ~(a & b);
      4'd11: y = ~(a | b);
      4'd12: y = b;
      4'd13: y = a;
      4'd14: y = {a[7:0], a[15:8]};
      default: y = a + b;
    endcase
    return {ov, co, y};
  endfunction

  always_comb begin
    logic [17:0] r;
    r = alu_ref(bus.alu_Mode, bus.alu_A, bus.alu_B, bus.alu_Cin);
    if (cur_vec >= 0 && cur_vec == inv_vec)   r[0]  = ~r[0];
    if (cur_vec >= 0 && cur_vec == force_vec) r[16] = 1'b1;
    bus.alu_Y        = r[15:0];
    bus.alu_Cout     = r[16];
    bus.alu_Overflow = r[17];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Software model: LFSR as shift with tap parity, MISR as multiply-by-x modulo x^16+x^15+x^2+1.
  task automatic build_model(input int fv, input int cv, output logic [15:0] sig);
    logic [31:0] l;
    logic [16:0] p;
    logic [17:0] r;
    logic [15:0] a, b, y;
    logic [3:0]  m;
    logic        cin, co, ov;
    l   = (SEED == 32'h0) ? 32'h1 : SEED;
    sig = 16'h0;
    for (int k = 0; k < NV; k++) begin
      a   = l[31:16];
      b   = l[15:0];
      cin = l[31] ^ l[0];
      m   = 4'(k % 16);
      exp_vec[k] = {a, b, cin, m};
      r  = alu_ref(m, a, b, cin);
      y  = r[15:0];
      co = r[16];
      ov = r[17];
      exp_cout[k] = co;
      if (k == fv) y[0] = ~y[0];
      if (k == cv) co = 1'b1;
      if (m != 4'd4 && m != 4'd5) begin
        co = 1'b0;
        ov = 1'b0;
      end
      p = {sig, 1'b0};
      if (p[16]) p = p ^ 17'h18005;
      sig = p[15:0] ^ y ^ {14'b0, co, ov};
      l = (l << 1) | {31'b0, ^(l & 32'h8020_0003)};
    end
  endtask

  task automatic run_one(input string tag, input int fv, input int cv, input int pulse_vec,
                         input int abort_vec, output logic [15:0] sig_out);
    int          c;
    bit          seen_done;
    logic [15:0] exp_sig;
    build_model(fv, cv, exp_sig);
    inv_vec   = fv;
    force_vec = cv;
    cur_vec   = -1;
    repeat ($urandom_range(1, 5)) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    cur_vec = 0;
    seen_done = 1'b0;
    while (!seen_done && c < PERIOD * NV + 20) begin
      if (c % PERIOD == 0 && c < PERIOD * NV) begin
        check({tag, "_vec"}, {bus.alu_A, bus.alu_B, bus.alu_Cin, bus.alu_Mode}, exp_vec[c / PERIOD]);
        check({tag, "_busy"}, {busy, done}, 2'b10);
      end
      if (abort_vec >= 0 && c == PERIOD * abort_vec) begin
        #3 rst = 1'b1;
        #1 check({tag, "_rst_now"},
                 {bus.alu_A, bus.alu_B, bus.alu_Cin, bus.alu_Mode, busy, done, vec_count, signature}, 0);
        cur_vec = -1;
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check({tag, "_after_rst"}, {busy, done, vec_count, signature}, 0);
        sig_out = signature;
        return;
      end
      start = (pulse_vec >= 0 && c == PERIOD * pulse_vec);
      @(posedge clk);
      #1 c++;
      cur_vec = c / PERIOD;
      if (done) seen_done = 1'b1;
    end
    start   = 1'b0;
    cur_vec = -1;
    check({tag, "_done_cycle"}, c, PERIOD * NV);
    check({tag, "_count"}, vec_count, NV);
    check({tag, "_idle"}, {busy, done}, 2'b01);
    check({tag, "_sig"}, signature, exp_sig);
    sig_out = signature;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] gold, s;
    int          fv, k4;
    rst   = 1'b1;
    start = 1'b0;
    #2 check("reset_async",
             {bus.alu_A, bus.alu_B, bus.alu_Cin, bus.alu_Mode, busy, done, vec_count, signature}, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check("reset_hold",
               {bus.alu_A, bus.alu_B, bus.alu_Cin, bus.alu_Mode, busy, done, vec_count, signature}, 0);
    end

    build_model(-1, -1, gold);
    check("model_first_vec", exp_vec[0], {16'hACE1, 16'h1D2B, 1'b0, 4'h0});

    run_one("full", -1, -1, -1, -1, gold);
    repeat (3) @(posedge clk);
    #1 check("done_hold", {done, busy, vec_count, signature}, {1'b1, 1'b0, 16'(NV), gold});

    run_one("busy", -1, -1, 30, -1, s);
    check("busy_same_sig", s, gold);

    run_one("abort", -1, -1, -1, 20, s);
    run_one("rerun", -1, -1, -1, -1, s);
    check("rerun_same_sig", s, gold);

    run_one("fault10", 10, -1, -1, -1, s);
    check("fault10_differs", s != gold, 1);

    fv = $urandom_range(0, NV - 1);
    run_one("fault_rnd", fv, -1, -1, -1, s);
    check("fault_rnd_differs", s != gold, 1);

    run_one("mask_m0", -1, 16, -1, -1, s);
    check("mask_m0_same", s, gold);

    k4 = -1;
    for (int k = 0; k < NV; k++)
      if (k4 < 0 && (k % 16 == 4 || k % 16 == 5) && !exp_cout[k]) k4 = k;
    if (k4 < 0) k4 = 4;
    build_model(-1, -1, s);
    run_one("mask_m4", -1, k4, -1, -1, s);
    if (!exp_cout[k4]) check("mask_m4_differs", s != gold, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Built-in self-test engine for the 16-bit ALU (A, B, Cin, Mode in; Y, Cout, Overflow out).
- Sits on the opposite side of the ALU interface from the ALU itself. It generates pseudo-random operand vectors, drives them into the ALU, samples the ALU responses and compacts them into a 16-bit signature.
- Replaces file-driven stimulus for on-chip checking. Software compares the final signature to a golden value.

Parameters:
NUM_VECTORS, 64, vectors applied per run (1..65535)
SEED, 32'hACE11D2B, initial 32-bit LFSR state; a value of 0 is replaced by 32'h00000001
SETTLE, 1, cycles a vector is held before sampling (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  begin a run; honoured only in IDLE or DONE
alu_A  output  16  operand A to ALU (registered)
alu_B  output  16  operand B to ALU (registered)
alu_Cin  output  1  carry-in to ALU (registered)
alu_Mode  output  4  operation select to ALU (registered)
alu_Y  input  16  ALU result
alu_Cout  input  1  ALU carry-out
alu_Overflow  input  1  ALU overflow
busy  output  1  high in DRIVE and SAMPLE
done  output  1  high in DONE
vec_count  output  16  number of vectors sampled in the current or last run
signature  output  16  MISR state

Behaviour:
- Reset (asynchronous, any state) forces the following:
  - State = IDLE.
  - alu_A, alu_B, alu_Cin, alu_Mode, vec_count and signature = 0.
  - busy = 0, done = 0.
  - LFSR = SEED, mode counter = 0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE or DONE with start=1 at an edge:
  - LFSR reloads SEED, signature clears to 0, vec_count clears to 0, mode counter clears to 0.
  - The vector is loaded from the SEED state; the next state is DRIVE.
  - done drops at the same edge.
- Vector mapping from LFSR state L and mode counter mc:
  - alu_A = L[31:16], alu_B = L[15:0].
  - alu_Cin = L[31] ^ L[0].
  - alu_Mode = mc, so every Mode 0..15 is exercised in order and the sequence wraps.
- DRIVE:
  - Hold the vector for SETTLE cycles using an internal counter.
  - After SETTLE cycles, go to SAMPLE. ALU inputs stay unchanged.
- SAMPLE (exactly one cycle; on its closing edge):
  - Masked flags: cm = alu_Cout and om = alu_Overflow only when alu_Mode is 4'b0100 or 4'b0101; otherwise cm = om = 0.
  - MISR update: s = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h8005 : 16'h0000); sig <= s ^ alu_Y ^ {14'b0, cm, om}.
  - vec_count increments.
  - LFSR steps: L <= {L[30:0], L[31]^L[21]^L[1]^L[0]}. mc <= mc+1 (mod 16).
  - If the incremented vec_count equals NUM_VECTORS, go to DONE and zero the ALU outputs.
  - Otherwise load the next vector from the stepped LFSR and go to DRIVE.
- Timing: with start taken at edge E0, vector k is driven from edge E0 + k*(SETTLE+1). done rises at edge E0 + NUM_VECTORS*(SETTLE+1).
- DONE: signature and vec_count hold; done stays 1 until start or rst.
- start while busy is ignored; the run continues unaffected.
- Reset mid-run aborts the run immediately. A subsequent run is bit-identical to an uninterrupted one.
- All state changes occur only at clk rising edges, except the asynchronous reset.

Test Plan:
- Reset check: assert rst mid-cycle with no clk edge -> all outputs 0 immediately; after release with start=0 for 10 cycles -> outputs stay 0, busy=0, done=0.
- Full run with the behavioural ALU model in the bench, default parameters:
  - start pulse -> first vector alu_A=16'hACE1, alu_B=16'h1D2B, alu_Cin=0, alu_Mode=0.
  - alu_Mode sequence 0,1,...,15,0,...
  - done rises exactly 128 cycles after the start edge, vec_count=64.
  - signature equals the bench software model of LFSR+MISR.
- Start while busy: pulse start at vector 30 -> no restart; done still rises at cycle 128; signature is identical to the previous run.
- Reset mid-run at vector 20 -> outputs zero, busy=0. A new start produces the same final signature as the full run.
- Fault detection: bench inverts alu_Y[0] only during vector 10 -> final signature differs from golden, vec_count=64.
- Flag masking: force alu_Cout=1 during a Mode 0000 vector -> signature unchanged from golden. Force it during a Mode 0100 vector where the model gives Cout=0 -> signature differs.
